// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared types and defaults for the button debounce reader
//
// Purpose : debouncer FSM state encoding, default timing constants and a
//           counter-width helper shared by the debounce reader files.
// Ports   : none (package).
package button_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  // 10 ms debounce and 1 s long press at 48 MHz.
  localparam int DEBOUNCE_CYCLES_DEFAULT   = 480_000;
  localparam int LONG_PRESS_CYCLES_DEFAULT = 48_000_000;

  // Width able to hold every terminal count of either counter; never below 1 bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for one asynchronous bit
//
// Purpose : brings an asynchronous pin into the clk domain.
// Ports   : clk   - sampling clock
//           rst_n - asynchronous active-low reset, both flops load RESET_VAL
//           d     - asynchronous input
//           q     - synchronized output, two clocks behind d
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/button_debounce_reader.sv
// rtl/button_debounce_reader.sv - debounced pushbutton reader with press/release/long-press strobes
//
// Purpose : synchronizes a raw button pin, debounces both edges with a
//           stability counter and reports level plus one-cycle event strobes.
//           Long-press detection is compiled in only when BTN_LONG_PRESS_EN
//           is defined; otherwise long_pulse is tied low.
// Ports   : clk           - single clock
//           rst_n         - asynchronous active-low reset
//           btn_in        - raw asynchronous button pin
//           pressed       - debounced level, 1 = pressed
//           press_pulse   - one-cycle strobe on accepted press
//           release_pulse - one-cycle strobe on accepted release
//           long_pulse    - one-cycle strobe once a press has been held LONG_PRESS_CYCLES
module button_debounce_reader
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEFAULT,
  parameter int LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEFAULT,
  parameter int ACTIVE_LOW        = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int             CW       = cnt_width(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES);
  localparam logic [CW-1:0]  DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  // Raw pin level when the button is released.
  localparam logic           IDLE_RAW = (ACTIVE_LOW != 0);

  logic       btn_sync;
  logic       s;
  btn_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic       pressed_q, pressed_d;
  logic       press_pulse_q, press_pulse_d;
  logic       release_pulse_q, release_pulse_d;

  sync_2ff #(
    .RESET_VAL (IDLE_RAW)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_in),
    .q     (btn_sync)
  );

  // s = 1 means pressed regardless of board wiring.
  assign s = btn_sync ^ IDLE_RAW;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (s) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = HELD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered from the next state so they change on the
    // same edge the FSM accepts the new level.
    pressed_d       = (state_d == HELD) || (state_d == RELEASE_WAIT);
    press_pulse_d   = pressed_d & ~pressed_q;
    release_pulse_d = ~pressed_d & pressed_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      pressed_q       <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      pressed_q       <= pressed_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
    end
  end

  assign pressed       = pressed_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;

`ifdef BTN_LONG_PRESS_EN
  localparam logic [CW-1:0] LP_LAST = CW'(LONG_PRESS_CYCLES - 1);
  localparam logic [CW-1:0] LP_PRE  = CW'(LONG_PRESS_CYCLES - 2);

  logic [CW-1:0] hold_q, hold_d;
  logic          hold_inc;
  logic          long_pulse_q, long_pulse_d;

  // Hold time restarts the cycle after press_pulse, survives release bounces
  // and saturates at its terminal value so long_pulse can only fire once.
  always_comb begin
    hold_d   = hold_q;
    hold_inc = 1'b0;
    if (press_pulse_q || (state_d == IDLE)) begin
      hold_d = '0;
    end else if (((state_q == HELD) || (state_q == RELEASE_WAIT)) && (hold_q != LP_LAST)) begin
      hold_d   = hold_q + 1'b1;
      hold_inc = 1'b1;
    end
    long_pulse_d = hold_inc && (hold_q == LP_PRE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q       <= '0;
      long_pulse_q <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      long_pulse_q <= long_pulse_d;
    end
  end

  assign long_pulse = long_pulse_q;
`else
  assign long_pulse = 1'b0;
`endif

endmodule
